// File: rtl/branch_seq_pkg.sv
// Shared definitions for the conditional-branch sequencer: state encoding,
// branch opcode, IR field positions and the datapath strobe bundle.
package branch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_e;

  localparam logic [4:0] BR_OPC_DEF = 5'b10010;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_C2_HI = 20;
  localparam int IR_C2_LO = 19;
  localparam int OPC_W    = IR_OP_HI - IR_OP_LO + 1;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic add;
  } strobes_t;

endpackage

// File: rtl/branch_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (enable && (r_q != '1)) begin
      r_q <= r_q + ONE;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/branch_seq.sv
// Fetch + conditional-branch control sequencer; non-branch opcodes are handed
// back to the main sequencer right after the IR is loaded.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter logic [OPC_W-1:0] BR_OPC = BR_OPC_DEF,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic [OPC_W-1:0] ir_op,
  input  logic             con,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             handoff,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rout,
  output logic             ConIn,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  state_e   r_state;
  state_e   w_state_next;
  logic     r_t1_first;
  logic     w_is_br;
  strobes_t w_strb;

  assign w_is_br = (ir_op == BR_OPC);

  // r_t1_first marks the entry cycle of T1 so the PC bumps only once per stall.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_t1_first <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_t1_first <= (r_state == T0);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (go) w_state_next = T0;
      T0:      w_state_next = T1;
      T1:      if (mem_ready) w_state_next = T2;
      T2:      w_state_next = T3;
      T3:      w_state_next = w_is_br ? T4 : IDLE;
      T4:      w_state_next = T5;
      T5:      w_state_next = T6;
      T6:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_strb  = '0;
    busy    = (r_state != IDLE);
    done    = 1'b0;
    handoff = 1'b0;
    unique case (r_state)
      IDLE: ;
      T0: begin
        w_strb.pc_out = 1'b1;
        w_strb.mar_in = 1'b1;
        w_strb.inc_pc = 1'b1;
        w_strb.z_in   = 1'b1;
      end
      T1: begin
        w_strb.zlow_out = 1'b1;
        w_strb.pc_in    = r_t1_first;
        w_strb.read     = 1'b1;
        w_strb.mdr_in   = 1'b1;
      end
      T2: begin
        w_strb.mdr_out = 1'b1;
        w_strb.ir_in   = 1'b1;
      end
      T3: begin
        w_strb.gra    = w_is_br;
        w_strb.r_out  = w_is_br;
        w_strb.con_in = w_is_br;
        handoff       = !w_is_br;
        done          = !w_is_br;
      end
      T4: begin
        w_strb.pc_out = 1'b1;
        w_strb.y_in   = 1'b1;
      end
      T5: begin
        w_strb.c_out = 1'b1;
        w_strb.add   = 1'b1;
        w_strb.z_in  = 1'b1;
      end
      T6: begin
        w_strb.zlow_out = 1'b1;
        w_strb.pc_in    = con;
        done            = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCout   = w_strb.pc_out;
  assign MARin   = w_strb.mar_in;
  assign IncPC   = w_strb.inc_pc;
  assign Zin     = w_strb.z_in;
  assign Zlowout = w_strb.zlow_out;
  assign PCin    = w_strb.pc_in;
  assign Read    = w_strb.read;
  assign MDRin   = w_strb.mdr_in;
  assign MDRout  = w_strb.mdr_out;
  assign IRin    = w_strb.ir_in;
  assign Gra     = w_strb.gra;
  assign Rout    = w_strb.r_out;
  assign ConIn   = w_strb.con_in;
  assign Yin     = w_strb.y_in;
  assign Cout    = w_strb.c_out;
  assign ADD     = w_strb.add;

  sat_cnt #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk    (clk),
    .clr    (clr),
    .enable ((r_state == T6) && con),
    .q      (taken_cnt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_nottaken_cnt (
    .clk    (clk),
    .clr    (clr),
    .enable ((r_state == T6) && !con),
    .q      (nottaken_cnt)
  );

endmodule

// File: tb/tb_branch_seq.sv
// Randomized bench for branch_seq: each transaction's per-cycle strobe trace
// is predicted from the phase table and compared cycle by cycle.
`timescale 1ns/1ps
module tb_branch_seq;

  localparam int         CW   = 2;
  localparam int         CMAX = (1 << CW) - 1;
  localparam logic [4:0] BR   = 5'b10010;

  localparam logic [15:0] M_PCOUT  = 16'h8000, M_MARIN  = 16'h4000, M_INCPC = 16'h2000,
                          M_ZIN    = 16'h1000, M_ZLO    = 16'h0800, M_PCIN  = 16'h0400,
                          M_READ   = 16'h0200, M_MDRIN  = 16'h0100, M_MDROUT = 16'h0080,
                          M_IRIN   = 16'h0040, M_GRA    = 16'h0020, M_ROUT  = 16'h0010,
                          M_CONIN  = 16'h0008, M_YIN    = 16'h0004, M_COUT  = 16'h0002,
                          M_ADD    = 16'h0001;

  logic clk = 1'b0;
  logic clr, go, con, mem_ready;
  logic [4:0] ir_op;
  logic busy, done, handoff;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic MDRout, IRin, Gra, Rout, ConIn, Yin, Cout, ADD;
  logic [CW-1:0] taken_cnt, nottaken_cnt;

  always #5 clk = ~clk;

  branch_seq #(.BR_OPC(BR), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .go(go), .ir_op(ir_op), .con(con), .mem_ready(mem_ready),
    .busy(busy), .done(done), .handoff(handoff),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Rout(Rout), .ConIn(ConIn), .Yin(Yin), .Cout(Cout), .ADD(ADD),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  wire [15:0] strobes = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                         MDRout, IRin, Gra, Rout, ConIn, Yin, Cout, ADD};
  wire [18:0] obs_now = {busy, done, handoff, strobes};

  logic [18:0] obs_q[$];
  logic [18:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_taken = 0;
  int m_nott = 0;

  function automatic logic [18:0] mk(bit b, bit d, bit h, logic [15:0] s);
    return {b, d, h, s};
  endfunction

  // Expected trace straight from the phase table, plus counter bookkeeping.
  task automatic model_txn(input logic [4:0] op, input bit c, input int stall);
    exp_q.push_back(mk(1, 0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
    for (int k = 0; k <= stall; k++)
      exp_q.push_back(mk(1, 0, 0, M_ZLO | M_READ | M_MDRIN | ((k == 0) ? M_PCIN : 16'h0)));
    exp_q.push_back(mk(1, 0, 0, M_MDROUT | M_IRIN));
    if (op != BR) begin
      exp_q.push_back(mk(1, 1, 1, 16'h0));
    end else begin
      exp_q.push_back(mk(1, 0, 0, M_GRA | M_ROUT | M_CONIN));
      exp_q.push_back(mk(1, 0, 0, M_PCOUT | M_YIN));
      exp_q.push_back(mk(1, 0, 0, M_COUT | M_ADD | M_ZIN));
      exp_q.push_back(mk(1, 1, 0, M_ZLO | (c ? M_PCIN : 16'h0)));
      if (c) m_taken = (m_taken < CMAX) ? m_taken + 1 : m_taken;
      else   m_nott  = (m_nott  < CMAX) ? m_nott  + 1 : m_nott;
    end
  endtask

  task automatic start_txn(input logic [4:0] op, input bit c);
    @(negedge clk);
    ir_op = op; con = c; go = 1'b1; mem_ready = 1'b0;
  endtask

  // Cycle i = 0 is T0; go stays high through cycle go_until, mem_ready rises after the stall.
  task automatic capture(input int ncyc, input int go_until, input int stall);
    obs_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      go = (i <= go_until);
      mem_ready = (i >= 1 + stall);
      #1 obs_q.push_back(obs_now);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; go = 1'b1; mem_ready = 1'b1; con = 1'b1; ir_op = BR;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (obs_now !== 19'h0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want %h", obs_now, 19'h0);
    end
    vectors++;
    if ({taken_cnt, nottaken_cnt} !== '0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", taken_cnt, nottaken_cnt);
    end
    @(negedge clk);
    clr = 1'b0; go = 1'b0; mem_ready = 1'b0;
    m_taken = 0; m_nott = 0;
  endtask

  task automatic test_single(input string name, input logic [4:0] op, input bit c, input int stall);
    exp_q.delete();
    model_txn(op, c, stall);
    exp_q.push_back(mk(0, 0, 0, 16'h0));
    start_txn(op, c);
    capture(exp_q.size(), -1, stall);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s cyc%0d op=%b con=%0d stall=%0d: got %h want %h",
                 name, i, op, c, stall, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (taken_cnt !== CW'(m_taken) || nottaken_cnt !== CW'(m_nott)) begin
      miscompares++;
      $display("FAIL %s_counters: got %0d/%0d want %0d/%0d",
               name, taken_cnt, nottaken_cnt, m_taken, m_nott);
    end
    $display("txn %s op=%b con=%0d stall=%0d cycles=%0d cnt=%0d/%0d",
             name, op, c, stall, exp_q.size(), taken_cnt, nottaken_cnt);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 1) == 1) ? BR : 5'($urandom_range(0, 31));
      test_single("random", op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    bit c;
    c = 1'($urandom_range(0, 1));
    exp_q.delete();
    model_txn(BR, c, 0);
    exp_q.push_back(mk(0, 0, 0, 16'h0));
    model_txn(BR, c, 0);
    exp_q.push_back(mk(0, 0, 0, 16'h0));
    start_txn(BR, c);
    capture(exp_q.size(), 7, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (taken_cnt !== CW'(m_taken) || nottaken_cnt !== CW'(m_nott)) begin
      miscompares++;
      $display("FAIL back_to_back_counters: got %0d/%0d want %0d/%0d",
               taken_cnt, nottaken_cnt, m_taken, m_nott);
    end
    $display("txn back_to_back con=%0d cycles=%0d cnt=%0d/%0d", c, exp_q.size(), taken_cnt, nottaken_cnt);
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 5; n++) test_single("saturate", BR, 1'b1, 0);
    vectors++;
    if (taken_cnt !== CW'(CMAX)) begin
      miscompares++; $display("FAIL saturation_hold: got %0d want %0d", taken_cnt, CMAX);
    end
  endtask

  task automatic test_clr_mid_stall;
    exp_q.delete();
    model_txn(BR, 1'b1, 10);
    start_txn(BR, 1'b1);
    capture(4, -1, 10);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL clr_stall_pre cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    m_taken = 0; m_nott = 0;
    vectors++;
    if (obs_now !== 19'h0) begin
      miscompares++; $display("FAIL clr_stall_outputs: got %h want %h", obs_now, 19'h0);
    end
    vectors++;
    if ({taken_cnt, nottaken_cnt} !== '0) begin
      miscompares++; $display("FAIL clr_stall_counters: got %0d/%0d want 0/0", taken_cnt, nottaken_cnt);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL clr_stall_idle: busy got %b want 0", busy);
    end
    $display("txn clr_mid_stall cnt=%0d/%0d busy=%0d", taken_cnt, nottaken_cnt, busy);
  endtask

  initial begin
    test_reset();
    test_single("taken", BR, 1'b1, 0);
    test_single("not_taken", BR, 1'b0, 0);
    test_single("stall", BR, 1'b1, 3);
    test_single("nonbranch", 5'b00011, 1'b1, 0);
    test_single("nonbranch_stall", 5'b00011, 1'b0, 2);
    test_random();
    test_back_to_back();
    test_saturation();
    test_clr_mid_stall();
    test_single("after_clr", BR, 1'b0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
